// File: rtl/bcd_controle.sv
// Measurement-window controller for the BCD frequency-meter digit chain.
// Optional post-load display hold: define BCD_HOLD_EN.
module bcd_controle #(
    parameter int GATE_CYCLES = 1000,
    parameter int HOLD_CYCLES = 500
) (
    input  logic ck,
    input  logic rst_s,
    input  logic run,
    input  logic sig,
    input  logic all_max,
    output logic cnt_rst,
    output logic cnt_enb,
    output logic ld,
    output logic gate,
    output logic busy,
    output logic ovf
);

    localparam int TW = $clog2(GATE_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(GATE_CYCLES - 1);
`ifdef BCD_HOLD_EN
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        GATE  = 3'd2,
        LOAD  = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_nxt;
    logic            r_s1;
    logic            r_s2;
    logic            r_s3;
    logic            w_edge;
    logic [TW-1:0]   r_timer;
    logic            r_sticky;
    logic            r_ovf;
    logic            r_cnt_rst;
    logic            r_ld;
    logic            r_gate;
    logic            r_busy;
`ifdef BCD_HOLD_EN
    logic [HW-1:0]   r_hold;
`endif

    // Pulse is built only from flops, so the digit enable cannot glitch.
    assign w_edge  = r_s2 & ~r_s3;
    assign cnt_enb = w_edge & (r_state == GATE);

    assign cnt_rst = r_cnt_rst;
    assign ld      = r_ld;
    assign gate    = r_gate;
    assign busy    = r_busy;
    assign ovf     = r_ovf;

    // Next-state decode; run is only consulted at window boundaries.
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (run) w_nxt = CLEAR;
                else     w_nxt = IDLE;
            end
            CLEAR: w_nxt = GATE;
            GATE: begin
                if (r_timer == T_LAST) w_nxt = LOAD;
                else                   w_nxt = GATE;
            end
            LOAD: begin
`ifdef BCD_HOLD_EN
                w_nxt = HOLD;
`else
                if (run) w_nxt = CLEAR;
                else     w_nxt = IDLE;
`endif
            end
            HOLD: begin
`ifdef BCD_HOLD_EN
                if (r_hold == H_LAST) begin
                    if (run) w_nxt = CLEAR;
                    else     w_nxt = IDLE;
                end else begin
                    w_nxt = HOLD;
                end
`else
                w_nxt = IDLE;
`endif
            end
            default: w_nxt = IDLE;
        endcase
    end

    // State, synchroniser, timers, overflow and Moore outputs registered from the next state.
    always_ff @(posedge ck) begin
        if (rst_s) begin
            r_state   <= IDLE;
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_s3      <= 1'b0;
            r_timer   <= '0;
            r_sticky  <= 1'b0;
            r_ovf     <= 1'b0;
            r_cnt_rst <= 1'b0;
            r_ld      <= 1'b0;
            r_gate    <= 1'b0;
            r_busy    <= 1'b0;
`ifdef BCD_HOLD_EN
            r_hold    <= '0;
`endif
        end else begin
            r_state   <= w_nxt;
            r_s1      <= sig;
            r_s2      <= r_s1;
            r_s3      <= r_s2;
            r_cnt_rst <= (w_nxt == CLEAR);
            r_gate    <= (w_nxt == GATE);
            r_ld      <= (w_nxt == LOAD);
            r_busy    <= (w_nxt != IDLE);
            case (r_state)
                CLEAR: begin
                    r_timer  <= '0;
                    r_sticky <= 1'b0;
                end
                GATE: begin
                    if (r_timer != T_LAST) r_timer <= r_timer + TW'(1);
                    else                   r_timer <= r_timer;
                    if (cnt_enb && all_max) r_sticky <= 1'b1;
                    else                    r_sticky <= r_sticky;
                end
                LOAD: begin
                    // Captured on the same edge the digit registers load.
                    r_ovf <= r_sticky;
`ifdef BCD_HOLD_EN
                    r_hold <= '0;
`endif
                end
                HOLD: begin
`ifdef BCD_HOLD_EN
                    r_hold <= r_hold + HW'(1);
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_controle.sv
// Randomised bench for bcd_controle against a window-position reference model.
module tb_bcd_controle;

    localparam int G = 20;
    localparam int H = 5;
`ifdef BCD_HOLD_EN
    localparam int LAST = G + 1 + H;
`else
    localparam int LAST = G + 1;
`endif

    logic ck = 1'b0;
    logic rst_s, run, sig, all_max;
    logic cnt_rst, cnt_enb, ld, gate, busy, ovf;

    bcd_controle #(.GATE_CYCLES(G), .HOLD_CYCLES(H)) dut (
        .ck(ck), .rst_s(rst_s), .run(run), .sig(sig), .all_max(all_max),
        .cnt_rst(cnt_rst), .cnt_enb(cnt_enb), .ld(ld), .gate(gate),
        .busy(busy), .ovf(ovf)
    );

    always #5 ck = ~ck;

    int total = 0;
    int bad = 0;

    // Model: position in the measurement period (-1 idle, 0 clear, 1..G gate, G+1 load, then hold).
    int       pos = -1;
    bit       m_sticky = 1'b0;
    bit       m_ovf = 1'b0;
    bit [2:0] hist = 3'b000;
    bit       periodic = 1'b0;
    int       seg = 2;
    int       enb_seen = 0;
    int       gap = 0;
    bit       gap_act = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic next_sig();
        if (seg > 1) begin
            seg--;
        end else begin
            sig = ~sig;
            seg = periodic ? 2 : int'($urandom_range(2, 5));
        end
    endtask

    task automatic cyc();
        bit enb_pre;
        bit e_gate, e_enb;
        @(posedge ck);
        enb_pre = hist[1] & ~hist[2] & (pos >= 1 && pos <= G);
        if (rst_s) begin
            pos = -1; m_sticky = 1'b0; m_ovf = 1'b0; hist = 3'b000;
        end else begin
            if (pos == 0) m_sticky = 1'b0;
            else if (enb_pre && all_max) m_sticky = 1'b1;
            if (pos == G + 1) m_ovf = m_sticky;
            if (pos == -1 || pos == LAST) pos = run ? 0 : -1;
            else pos++;
            hist = {hist[1:0], sig};
        end
        #1;
        e_gate = (pos >= 1 && pos <= G);
        e_enb  = hist[1] & ~hist[2] & e_gate;
        chk("outs", {26'd0, cnt_rst, cnt_enb, ld, gate, busy, ovf},
            {26'd0, pos == 0, e_enb, pos == G + 1, e_gate, pos != -1, m_ovf});
        if (gap_act) begin
            if (cnt_rst) begin
                chk("gap", gap, LAST - G - 1);
                gap_act = 1'b0;
            end else if (!busy) gap_act = 1'b0;
            else gap++;
        end
        if (cnt_rst) enb_seen = 0;
        else if (cnt_enb) enb_seen++;
        if (ld) begin
            gap_act = 1'b1;
            gap = 0;
            if (periodic) chk("pulses", enb_seen, 5);
        end
        next_sig();
    endtask

    task automatic wait_ld();
        int n = 0;
        cyc();
        while (!ld && n < LAST + 5) begin cyc(); n++; end
        chk("ld_seen", ld, 1'b1);
    endtask

    task automatic wait_clr();
        int n = 0;
        cyc();
        while (!cnt_rst && n < LAST + 5) begin cyc(); n++; end
        chk("clr_seen", cnt_rst, 1'b1);
    endtask

    initial begin
        rst_s = 1'b1; run = 1'b0; sig = 1'b0; all_max = 1'b0;
        cyc(); cyc();
        chk("reset", {cnt_rst, cnt_enb, ld, gate, busy, ovf}, 6'd0);
        rst_s = 1'b0;
        for (int i = 0; i < 30; i++) cyc();

        // Regular 2-high/2-low signal: five pulses per window.
        periodic = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        run = 1'b1;
        for (int w = 0; w < 3; w++) wait_ld();

        all_max = 1'b1;
        wait_ld(); cyc();
        chk("ovf_hi", ovf, 1'b1);
        all_max = 1'b0;
        wait_ld(); cyc();
        chk("ovf_lo", ovf, 1'b0);

        // Reset in window cycle 7, then restart.
        wait_clr();
        for (int i = 0; i < 7; i++) cyc();
        rst_s = 1'b1; cyc(); rst_s = 1'b0;
        chk("rst_abort", {cnt_rst, cnt_enb, ld, gate, busy, ovf}, 6'd0);
        cyc();
        chk("restart", cnt_rst, 1'b1);

        // Random signal and overflow input across several windows.
        periodic = 1'b0;
        for (int i = 0; i < 5 * (LAST + 1); i++) begin
            all_max = ($urandom_range(0, 3) == 0);
            cyc();
        end
        all_max = 1'b0;

        // Drop run mid-window: window completes, then idle.
        wait_clr();
        for (int i = 0; i < 10; i++) cyc();
        run = 1'b0;
        wait_ld();
        for (int i = 0; i < 12; i++) cyc();
        chk("idle_after_drop", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
